// File: rtl/delay_line_pkg.sv
// Shared defaults, fine-stage state encoding and pointer arithmetic for the
// coarse/fine feedback delay line.
package delay_line_pkg;

  localparam int DATA_WIDTH    = 17;
  localparam int LOG2_FINE_MAX = 3;
  localparam int LOG2_DEPTH    = 4;

  typedef enum logic {
    IDLE,
    PENDING
  } fine_state_e;

  // Read address k samples behind the write pointer, wrapped to the ring size.
  function automatic int unsigned ptr_sub(input int unsigned wr_ptr,
                                          input int unsigned k,
                                          input int unsigned log2_depth);
    return (wr_ptr - k) & ((32'd1 << log2_depth) - 32'd1);
  endfunction

endpackage

// File: rtl/coarse_fine_delay_line_if.sv
// Sample stream, delay settings and overrun flag of the delay line, bundled so
// the producer (master) and the delay line (slave) connect through one port.
interface coarse_fine_delay_line_if #(
  parameter int DATA_WIDTH    = delay_line_pkg::DATA_WIDTH,
  parameter int LOG2_FINE_MAX = delay_line_pkg::LOG2_FINE_MAX,
  parameter int LOG2_DEPTH    = delay_line_pkg::LOG2_DEPTH
);

  logic                     data_valid_i;
  logic [DATA_WIDTH-1:0]    data_i;
  logic [LOG2_FINE_MAX-1:0] fine_delay_i;
  logic [LOG2_DEPTH-1:0]    coarse_delay_i;
  logic                     overrun_clr_i;
  logic                     data_valid_o;
  logic [DATA_WIDTH-1:0]    data_o;
  logic                     overrun_o;

  modport master (
    output data_valid_i, data_i, fine_delay_i, coarse_delay_i, overrun_clr_i,
    input  data_valid_o, data_o, overrun_o
  );

  modport slave (
    input  data_valid_i, data_i, fine_delay_i, coarse_delay_i, overrun_clr_i,
    output data_valid_o, data_o, overrun_o
  );

endinterface

// File: rtl/delay_ring_buffer.sv
// Coarse delay: ring buffer of past samples with a registered read k samples
// back; k=0 passes the incoming sample straight into the read register.
module delay_ring_buffer #(
  parameter int DATA_WIDTH = delay_line_pkg::DATA_WIDTH,
  parameter int LOG2_DEPTH = delay_line_pkg::LOG2_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LOG2_DEPTH-1:0] delay,
  output logic [DATA_WIDTH-1:0] rd_data
);
  import delay_line_pkg::*;

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign rd_addr = LOG2_DEPTH'(ptr_sub(32'(wr_ptr_q), 32'(delay), LOG2_DEPTH));
  assign rd_data = rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_data_q <= '0;
      // NOTE: the storage is cleared on reset because entries not yet written
      // must read back as zero; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
      rd_data_q       <= (delay == '0) ? wr_data : mem_q[rd_addr];
      wr_ptr_q        <= wr_ptr_q + LOG2_DEPTH'(1);
    end
  end

endmodule

// File: rtl/coarse_fine_delay_line.sv
// Two-stage feedback delay: whole-sample coarse delay, then a per-sample fine
// delay in clocks. Define COARSE_DELAY_EN to build in the ring buffer.
module coarse_fine_delay_line #(
  parameter int DATA_WIDTH    = delay_line_pkg::DATA_WIDTH,
  parameter int LOG2_FINE_MAX = delay_line_pkg::LOG2_FINE_MAX,
  parameter int LOG2_DEPTH    = delay_line_pkg::LOG2_DEPTH
) (
  input logic                     clk_i,
  input logic                     rst_i,
  coarse_fine_delay_line_if.slave bus
);
  import delay_line_pkg::*;

  // Coarse stage outputs, valid together in the cycle after data_valid_i.
  logic                     coarse_valid_q;
  logic [LOG2_FINE_MAX-1:0] fine_q;
  logic [DATA_WIDTH-1:0]    coarse_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coarse_valid_q <= 1'b0;
      fine_q         <= '0;
    end else begin
      coarse_valid_q <= bus.data_valid_i;
      if (bus.data_valid_i) fine_q <= bus.fine_delay_i;
    end
  end

`ifdef COARSE_DELAY_EN
  delay_ring_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (bus.data_valid_i),
    .wr_data (bus.data_i),
    .delay   (bus.coarse_delay_i),
    .rd_data (coarse_data)
  );
`else
  logic [DATA_WIDTH-1:0] coarse_data_q;
  logic                  unused_coarse_delay;

  assign unused_coarse_delay = ^bus.coarse_delay_i;
  assign coarse_data         = coarse_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coarse_data_q <= '0;
    end else if (bus.data_valid_i) begin
      coarse_data_q <= bus.data_i;
    end
  end
`endif

  // Fine stage
  fine_state_e              state_q, state_d;
  logic [LOG2_FINE_MAX-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    hold_q, hold_d;
  logic                     emit;
  logic                     drop;
  logic [DATA_WIDTH-1:0]    emit_data;
  logic                     data_valid_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     overrun_q;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    emit      = 1'b0;
    drop      = 1'b0;
    emit_data = hold_q;

    if (state_q == PENDING) begin
      if (cnt_q == '0) begin
        emit    = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - LOG2_FINE_MAX'(1);
        drop  = coarse_valid_q;
      end
    end

    // A new sample always loads; only the pending one can be lost.
    if (coarse_valid_q) begin
      hold_d = coarse_data;
      if (fine_q == '0) begin
        // An old sample due on this same edge cannot share the strobe.
        drop      = drop | emit;
        emit      = 1'b1;
        emit_data = coarse_data;
        cnt_d     = '0;
        state_d   = IDLE;
      end else begin
        cnt_d   = fine_q - LOG2_FINE_MAX'(1);
        state_d = PENDING;
      end
    end
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      data_valid_q <= emit;
      if (emit) data_q <= emit_data;
      overrun_q    <= drop | (overrun_q & ~bus.overrun_clr_i);
    end
  end

  assign bus.data_valid_o = data_valid_q;
  assign bus.data_o       = data_q;
  assign bus.overrun_o    = overrun_q;

endmodule

// File: tb/tb_coarse_fine_delay_line.sv
// Scoreboard bench for coarse_fine_delay_line: stimulus pushes expected
// outputs from a sample-history model; a monitor pops and compares strobes.
module tb_coarse_fine_delay_line;
  import delay_line_pkg::*;

  typedef struct {
    int                    cyc;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t                  exp_q[$];
  logic [DATA_WIDTH-1:0] hist[$];
  int                    last_t;
  int                    last_f;
  bit                    has_last;
  bit                    model_ovr;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  coarse_fine_delay_line_if #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LOG2_FINE_MAX (LOG2_FINE_MAX),
    .LOG2_DEPTH    (LOG2_DEPTH)
  ) bus ();

  coarse_fine_delay_line #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LOG2_FINE_MAX (LOG2_FINE_MAX),
    .LOG2_DEPTH    (LOG2_DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (bus.data_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(bus.data_o), 32'(e.data));
        check("out_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    has_last  = 1'b0;
    model_ovr = 1'b0;
  endtask

  task automatic apply_reset();
    rst_i                = 1'b1;
    bus.data_valid_i     = 1'b0;
    bus.overrun_clr_i    = 1'b0;
    model_reset();
    idle(2);
    rst_i = 1'b0;
  endtask

  // Issue one sample in the current cycle and record what should come out.
  task automatic send(input logic [DATA_WIDTH-1:0] d, input int k, input int f);
    int                    t;
    int                    n;
    logic [DATA_WIDTH-1:0] cv;
    t = cyc;
    if (has_last && last_f > 0 && (t - last_t) < last_f) begin
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      model_ovr = 1'b1;
    end
    cv = d;
    n  = hist.size();
`ifdef COARSE_DELAY_EN
    if (k != 0) cv = (n >= k) ? hist[n-k] : '0;
`endif
    exp_q.push_back('{t + 2 + f, cv});
    hist.push_back(d);
    has_last = 1'b1;
    last_t   = t;
    last_f   = f;
    bus.data_valid_i   = 1'b1;
    bus.data_i         = d;
    bus.fine_delay_i   = LOG2_FINE_MAX'(f);
    bus.coarse_delay_i = LOG2_DEPTH'(k);
    idle(1);
    bus.data_valid_i   = 1'b0;
    bus.data_i         = DATA_WIDTH'($urandom);
    bus.fine_delay_i   = LOG2_FINE_MAX'($urandom);
    bus.coarse_delay_i = LOG2_DEPTH'($urandom);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      idle(1);
      budget++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    idle(4);
  endtask

  task automatic clear_overrun();
    bus.overrun_clr_i = 1'b1;
    idle(1);
    bus.overrun_clr_i = 1'b0;
    model_ovr         = 1'b0;
  endtask

  initial begin
    int f;
    int gap;
    bus.data_valid_i   = 1'b0;
    bus.data_i         = '0;
    bus.fine_delay_i   = '0;
    bus.coarse_delay_i = '0;
    bus.overrun_clr_i  = 1'b0;
    idle(1);
    apply_reset();
    check("rst_valid", 32'(bus.data_valid_o), 32'd0);
    check("rst_data", 32'(bus.data_o), 32'd0);
    check("rst_overrun", 32'(bus.overrun_o), 32'd0);

    // Minimum latency, no fine delay.
    send(17'h00005, 0, 0);
    drain();
    check("f0_overrun", 32'(bus.overrun_o), 32'd0);

    // Fine delay of 5, well spaced.
    send(17'h1, 0, 5);
    idle(7);
    send(17'h2, 0, 5);
    drain();
    check("f5_overrun", 32'(bus.overrun_o), 32'd0);

    // Coarse delay 3 across a pointer wrap.
    for (int i = 1; i <= 20; i++) begin
      send(DATA_WIDTH'(i), 3, 0);
      idle(3);
    end
    drain();

    // Overrun: B arrives 3 cycles after A with f=6.
    send(17'h0AAAA, 0, 6);
    idle(2);
    send(17'h0BBBB, 0, 6);
    check("ovr_before_drop", 32'(bus.overrun_o), 32'd0);
    idle(1);
    check("ovr_after_drop", 32'(bus.overrun_o), 32'd1);
    drain();
    check("ovr_sticky", 32'(bus.overrun_o), 32'(model_ovr));
    clear_overrun();
    check("ovr_cleared", 32'(bus.overrun_o), 32'd0);

    // Spacing exactly f: both emitted, no overrun.
    send(17'h0CCCC, 0, 6);
    idle(5);
    send(17'h0DDDD, 0, 6);
    drain();
    check("spacing_f_overrun", 32'(bus.overrun_o), 32'd0);

    // Reset while a sample is pending.
    send(17'h1ABCD, 0, 6);
    idle(3);
    apply_reset();
    idle(8);
    check("midrst_data", 32'(bus.data_o), 32'd0);
    check("midrst_overrun", 32'(bus.overrun_o), 32'd0);
    send(17'h00011, 2, 0);
    idle(2);
    send(17'h00022, 2, 0);
    idle(2);
    send(17'h00033, 2, 0);
    drain();

    // Non-zero coarse delay request (ignored when the buffer is not built).
    send(17'h12345, 7, 2);
    idle(2);
    send(17'h0F0F0, 7, 2);
    drain();

    // Randomized phases; the later ones allow overruns.
    for (int p = 0; p < 4; p++) begin
      f = $urandom_range(0, (1 << LOG2_FINE_MAX) - 1);
      for (int i = 0; i < 25; i++) begin
        send(DATA_WIDTH'($urandom), $urandom_range(0, (1 << LOG2_DEPTH) - 1), f);
        if (p < 2) gap = $urandom_range((f > 1) ? f : 1, f + 3);
        else       gap = $urandom_range(1, f + 3);
        idle(gap - 1);
      end
      drain();
      check("rand_overrun", 32'(bus.overrun_o), 32'(model_ovr));
      clear_overrun();
      check("rand_ovr_cleared", 32'(bus.overrun_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
    $fatal(1);
  end

endmodule
